// File: rtl/gray_code_counter_if.sv
// Bundles the counter controls/status and the Gray-to-binary decoder channel.
// The master side drives the controls; the counter sits on the slave side.
interface gray_code_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             wrap;
    logic [WIDTH-1:0] g2b_in;
    logic             g2b_vin;
    logic [WIDTH-1:0] g2b_out;
    logic             g2b_vout;

    modport master (
        output en, up, load, load_bin, g2b_in, g2b_vin,
        input  bin, gray, wrap, g2b_out, g2b_vout
    );

    modport slave (
        input  en, up, load, load_bin, g2b_in, g2b_vin,
        output bin, gray, wrap, g2b_out, g2b_vout
    );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down binary counter with a registered Gray-code mirror and roll-over pulse,
// plus an independent one-cycle-latency Gray-to-binary decoder.
module gray_code_counter #(
    parameter int WIDTH = 3
) (
    input logic                clk,
    input logic                rst_n,
    gray_code_counter_if.slave bus
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] g2b_out_q;
    logic             g2b_vout_q;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always_comb begin
        bin_next = bin_q;
        if (bus.up) begin
            bin_next = bin_q + WIDTH'(1);
        end else begin
            bin_next = bin_q - WIDTH'(1);
        end
    end

    // Gray is computed from the next binary value so both registers move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else if (bus.load) begin
            bin_q  <= bus.load_bin;
            gray_q <= to_gray(bus.load_bin);
            wrap_q <= 1'b0;
        end else if (bus.en) begin
            bin_q  <= bin_next;
            gray_q <= to_gray(bin_next);
            wrap_q <= bus.up ? (&bin_q) : ~(|bin_q);
        end else begin
            wrap_q <= 1'b0;
        end
    end

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec[i] = ^(bus.g2b_in >> i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g2b_out_q  <= '0;
            g2b_vout_q <= 1'b0;
        end else begin
            g2b_vout_q <= bus.g2b_vin;
            if (bus.g2b_vin) begin
                g2b_out_q <= dec;
            end
        end
    end

    assign bus.bin      = bin_q;
    assign bus.gray     = gray_q;
    assign bus.wrap     = wrap_q;
    assign bus.g2b_out  = g2b_out_q;
    assign bus.g2b_vout = g2b_vout_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Randomized self-checking bench for gray_code_counter at WIDTH=3 and WIDTH=8,
// compared against an arithmetic reference model of counting and decoding.
module tb_gray_code_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    gray_code_counter_if #(.WIDTH(3)) bus3 ();
    gray_code_counter_if #(.WIDTH(8)) bus8 ();

    gray_code_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
    gray_code_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int m_bin, m_wrap, m_gout, m_vout;

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the binary value whose Gray code equals g.
    function automatic int decode_ref(input int g, input int w);
        for (int b = 0; b < (1 << w); b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        bus3.en = 0; bus3.up = 0; bus3.load = 0; bus3.load_bin = '0;
        bus3.g2b_in = '0; bus3.g2b_vin = 0;
        bus8.en = 0; bus8.up = 0; bus8.load = 0; bus8.load_bin = '0;
        bus8.g2b_in = '0; bus8.g2b_vin = 0;
    endtask

    task automatic model_reset();
        m_bin = 0; m_wrap = 0; m_gout = 0; m_vout = 0;
    endtask

    // One rising edge on the 3-bit DUT with the model advanced from the same inputs.
    task automatic tick3();
        int l, e, u, lb, vin, gin;
        l = bus3.load; e = bus3.en; u = bus3.up; lb = bus3.load_bin;
        vin = bus3.g2b_vin; gin = bus3.g2b_in;
        @(posedge clk);
        if (l) begin
            m_bin = lb; m_wrap = 0;
        end else if (e) begin
            if (u) begin
                m_wrap = (m_bin == 7);
                m_bin = (m_bin + 1) % 8;
            end else begin
                m_wrap = (m_bin == 0);
                m_bin = (m_bin + 7) % 8;
            end
        end else begin
            m_wrap = 0;
        end
        m_vout = vin;
        if (vin) m_gout = decode_ref(gin, 3);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus3.en = 1; bus3.up = 1; bus3.load = 1; bus3.load_bin = 3'b101;
        bus3.g2b_vin = 1; bus3.g2b_in = 3'b110;
        @(posedge clk);
        #1;
        total++;
        if (bus3.bin !== 3'b000 || bus3.gray !== 3'b000 || bus3.wrap !== 1'b0) begin
            $display("[TB] FAIL reset_counter: bin=%b gray=%b wrap=%b, required 000 000 0", bus3.bin, bus3.gray, bus3.wrap);
        end else passed++;
        total++;
        if (bus3.g2b_out !== 3'b000 || bus3.g2b_vout !== 1'b0) begin
            $display("[TB] FAIL reset_decoder: g2b_out=%b g2b_vout=%b, required 000 0", bus3.g2b_out, bus3.g2b_vout);
        end else passed++;
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        logic [2:0] exp_gray [8];
        exp_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        bus3.en = 1; bus3.up = 1;
        for (int i = 0; i < 8; i++) begin
            tick3();
            total++;
            if (bus3.gray !== exp_gray[i]) begin
                $display("[TB] FAIL count_up_gray step %0d: got %b, required %b", i, bus3.gray, exp_gray[i]);
            end else passed++;
            total++;
            if (bus3.wrap !== (i == 7)) begin
                $display("[TB] FAIL count_up_wrap step %0d: got %b, required %b", i, bus3.wrap, (i == 7));
            end else passed++;
        end
        bus3.en = 0;
    endtask

    task automatic test_load();
        bus3.load = 1; bus3.load_bin = 3'b010;
        tick3();
        total++;
        if (bus3.bin !== 3'b010) begin
            $display("[TB] FAIL load_first: bin=%b, required 010", bus3.bin);
        end else passed++;
        bus3.load_bin = 3'b101; bus3.en = 1; bus3.up = 1;
        tick3();
        total++;
        if (bus3.bin !== 3'b101 || bus3.gray !== 3'b111 || bus3.wrap !== 1'b0) begin
            $display("[TB] FAIL load_over_en: bin=%b gray=%b wrap=%b, required 101 111 0", bus3.bin, bus3.gray, bus3.wrap);
        end else passed++;
        bus3.load = 0; bus3.en = 0;
    endtask

    task automatic test_count_down();
        pulse_reset();
        bus3.en = 1; bus3.up = 0;
        tick3();
        total++;
        if (bus3.bin !== 3'b111 || bus3.gray !== 3'b100 || bus3.wrap !== 1'b1) begin
            $display("[TB] FAIL down_wrap: bin=%b gray=%b wrap=%b, required 111 100 1", bus3.bin, bus3.gray, bus3.wrap);
        end else passed++;
        tick3();
        total++;
        if (bus3.bin !== 3'b110 || bus3.gray !== 3'b101 || bus3.wrap !== 1'b0) begin
            $display("[TB] FAIL down_next: bin=%b gray=%b wrap=%b, required 110 101 0", bus3.bin, bus3.gray, bus3.wrap);
        end else passed++;
        bus3.en = 0;
    endtask

    task automatic test_decoder();
        bus3.g2b_vin = 1; bus3.g2b_in = 3'b110;
        tick3();
        total++;
        if (bus3.g2b_out !== 3'b100 || bus3.g2b_vout !== 1'b1) begin
            $display("[TB] FAIL decode_110: g2b_out=%b g2b_vout=%b, required 100 1", bus3.g2b_out, bus3.g2b_vout);
        end else passed++;
        for (int b = 0; b < 8; b++) begin
            bus3.g2b_in = 3'(gray_of(b));
            tick3();
            total++;
            if (bus3.g2b_out !== 3'(b) || bus3.g2b_vout !== 1'b1) begin
                $display("[TB] FAIL decode_roundtrip %0d: g2b_out=%b vout=%b, required %b 1", b, bus3.g2b_out, bus3.g2b_vout, 3'(b));
            end else passed++;
        end
        bus3.g2b_vin = 0; bus3.g2b_in = 3'b011;
        tick3();
        total++;
        if (bus3.g2b_vout !== 1'b0 || bus3.g2b_out !== 3'b111) begin
            $display("[TB] FAIL decode_hold: g2b_out=%b vout=%b, required 111 0", bus3.g2b_out, bus3.g2b_vout);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        bus3.en = 1; bus3.up = 1; bus3.g2b_vin = 1; bus3.g2b_in = 3'b101;
        for (int i = 0; i < 5; i++) tick3();
        total++;
        if (bus3.bin !== 3'b101 || bus3.g2b_vout !== 1'b1) begin
            $display("[TB] FAIL mid_precount: bin=%b vout=%b, required 101 1", bus3.bin, bus3.g2b_vout);
        end else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus3.bin !== 3'b000 || bus3.gray !== 3'b000 || bus3.wrap !== 1'b0 ||
            bus3.g2b_out !== 3'b000 || bus3.g2b_vout !== 1'b0) begin
            $display("[TB] FAIL mid_async_reset: bin=%b gray=%b wrap=%b g2b_out=%b vout=%b, required all 0",
                     bus3.bin, bus3.gray, bus3.wrap, bus3.g2b_out, bus3.g2b_vout);
        end else passed++;
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick3();
            total++;
            if (bus3.bin !== 3'b000 || bus3.gray !== 3'b000 || bus3.wrap !== 1'b0 || bus3.g2b_vout !== 1'b0) begin
                $display("[TB] FAIL mid_hold step %0d: bin=%b gray=%b wrap=%b vout=%b, required 000 000 0 0",
                         i, bus3.bin, bus3.gray, bus3.wrap, bus3.g2b_vout);
            end else passed++;
        end
    endtask

    task automatic test_random();
        logic [2:0] prev_gray;
        int counting;
        for (int n = 0; n < 300; n++) begin
            bus3.load     = ($urandom_range(0, 7) == 0);
            bus3.en       = $urandom_range(0, 3) != 0;
            bus3.up       = $urandom_range(0, 1);
            bus3.load_bin = 3'($urandom_range(0, 7));
            bus3.g2b_vin  = $urandom_range(0, 1);
            bus3.g2b_in   = 3'($urandom_range(0, 7));
            prev_gray = bus3.gray;
            counting  = !bus3.load && bus3.en;
            tick3();
            total++;
            if (bus3.bin !== 3'(m_bin) || bus3.gray !== 3'(gray_of(m_bin)) || bus3.wrap !== 1'(m_wrap)) begin
                $display("[TB] FAIL random_counter %0d: bin=%b gray=%b wrap=%b, required %b %b %0d",
                         n, bus3.bin, bus3.gray, bus3.wrap, 3'(m_bin), 3'(gray_of(m_bin)), m_wrap);
            end else passed++;
            total++;
            if (bus3.g2b_out !== 3'(m_gout) || bus3.g2b_vout !== 1'(m_vout)) begin
                $display("[TB] FAIL random_decoder %0d: g2b_out=%b vout=%b, required %b %0d",
                         n, bus3.g2b_out, bus3.g2b_vout, 3'(m_gout), m_vout);
            end else passed++;
            if (counting) begin
                total++;
                if ($countones(prev_gray ^ bus3.gray) != 1) begin
                    $display("[TB] FAIL random_hamming %0d: %b -> %b, required distance 1", n, prev_gray, bus3.gray);
                end else passed++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_width8();
        logic [7:0] prev_gray;
        int wraps;
        pulse_reset();
        for (int dir = 1; dir >= 0; dir--) begin
            bus8.en = 1; bus8.up = 1'(dir);
            wraps = 0;
            for (int i = 0; i < 256; i++) begin
                prev_gray = bus8.gray;
                @(posedge clk);
                #1;
                if (bus8.wrap === 1'b1) wraps++;
                total++;
                if ($countones(prev_gray ^ bus8.gray) != 1 || bus8.gray !== 8'(gray_of(bus8.bin))) begin
                    $display("[TB] FAIL w8_step dir=%0d %0d: %h -> %h (bin %h)", dir, i, prev_gray, bus8.gray, bus8.bin);
                end else passed++;
            end
            total++;
            if (wraps != 1 || bus8.bin !== 8'h00) begin
                $display("[TB] FAIL w8_wraps dir=%0d: wraps=%0d bin=%h, required 1 00", dir, wraps, bus8.bin);
            end else passed++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_count_up();
        test_load();
        test_count_down();
        test_decoder();
        test_reset_mid();
        test_random();
        test_width8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
